// File: rtl/preemph_fir.sv
// Pre-emphasis FIR y[n] = DEQ(C0*x[n]) + DEQ(C1*x[n-1]), Q10 coefficients, wrapping arithmetic.
// Five-state sequencer between two FIFOs: read -> multiply -> dequantise -> sum -> write.
module preemph_fir #(
  parameter int DATA_WIDTH = 32,
  parameter int C0         = 2876,
  parameter int C1         = -1870
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         in_empty,
  output logic                         in_rd_en,
  output logic signed [DATA_WIDTH-1:0] dout,
  input  logic                         out_full,
  output logic                         out_wr_en
);

  typedef enum logic [2:0] {S_READ, S_MUL, S_DQ, S_SUM, S_WRITE} state_t;

  localparam logic signed [DATA_WIDTH-1:0] C0_W = DATA_WIDTH'(C0);
  localparam logic signed [DATA_WIDTH-1:0] C1_W = DATA_WIDTH'(C1);

  state_t                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   x_cur_q, x_cur_d;
  logic signed [DATA_WIDTH-1:0]   x_prev_q, x_prev_d;
  logic signed [DATA_WIDTH-1:0]   p0_q, p0_d;
  logic signed [DATA_WIDTH-1:0]   p1_q, p1_d;
  logic signed [DATA_WIDTH-1:0]   y_q, y_d;
  logic signed [2*DATA_WIDTH-1:0] prod0, prod1;

  // Full-width signed products; only the low DATA_WIDTH bits are kept.
  assign prod0 = $signed({{DATA_WIDTH{x_cur_q[DATA_WIDTH-1]}}, x_cur_q})
               * $signed({{DATA_WIDTH{C0_W[DATA_WIDTH-1]}}, C0_W});
  assign prod1 = $signed({{DATA_WIDTH{x_prev_q[DATA_WIDTH-1]}}, x_prev_q})
               * $signed({{DATA_WIDTH{C1_W[DATA_WIDTH-1]}}, C1_W});

  assign dout = y_q;

  always_comb begin
    state_d   = state_q;
    x_cur_d   = x_cur_q;
    x_prev_d  = x_prev_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    y_d       = y_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    case (state_q)
      S_READ: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          x_cur_d  = din;
          x_prev_d = x_cur_q;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        p0_d    = prod0[DATA_WIDTH-1:0];
        p1_d    = prod1[DATA_WIDTH-1:0];
        state_d = S_DQ;
      end
      S_DQ: begin
        p0_d    = p0_q >>> 10;
        p1_d    = p1_q >>> 10;
        state_d = S_SUM;
      end
      S_SUM: begin
        y_d     = p0_q + p1_q;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          state_d   = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
    // Reset masks the strobes so no FIFO is touched while it is held.
    if (reset) begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_READ;
      x_cur_q  <= '0;
      x_prev_q <= '0;
      p0_q     <= '0;
      p1_q     <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      x_cur_q  <= x_cur_d;
      x_prev_q <= x_prev_d;
      p0_q     <= p0_d;
      p1_q     <= p1_d;
      y_q      <= y_d;
    end
  end

endmodule

// File: tb/tb_preemph_fir.sv
// Directed bench for preemph_fir: step, rounding, impulse, backpressure, random starvation, mid-op reset.
module tb_preemph_fir;

  logic               clock;
  logic               reset;
  logic signed [31:0] din;
  logic               in_empty;
  logic               in_rd_en;
  logic signed [31:0] dout;
  logic               out_full;
  logic               out_wr_en;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_cyc = 0;

  preemph_fir dut (
    .clock    (clock),
    .reset    (reset),
    .din      (din),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .dout     (dout),
    .out_full (out_full),
    .out_wr_en(out_wr_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input logic signed [31:0] obs, input logic signed [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: truncated products, floor shift, wrapping sum.
  function automatic logic signed [31:0] model(input logic signed [31:0] x, input logic signed [31:0] xp);
    logic signed [63:0] m0, m1;
    logic signed [31:0] t0, t1;
    m0 = 64'(x) * 64'sd2876;
    m1 = 64'(xp) * -64'sd1870;
    t0 = m0[31:0];
    t1 = m1[31:0];
    return (t0 >>> 10) + (t1 >>> 10);
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_empty = 1'b1; out_full = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic feed(input logic signed [31:0] v, input string tag);
    int n = 0;
    @(negedge clock);
    din = v; in_empty = 1'b0;
    #1;
    while (!in_rd_en && n < 20) begin
      @(negedge clock); #1; n++;
    end
    check(32'(in_rd_en), 1, {tag, "_rd_seen"});
    rd_cyc = cyc;
    @(posedge clock); #1;
    in_empty = 1'b1;
  endtask

  task automatic expect_write(input logic signed [31:0] exp, input string tag);
    int n = 0;
    out_full = 1'b0;
    #1;
    while (!out_wr_en && n < 20) begin
      @(negedge clock); #1; n++;
    end
    check(32'(out_wr_en), 1, {tag, "_wr_seen"});
    check(dout, exp, tag);
    check(cyc - rd_cyc, 4, {tag, "_latency"});
    @(posedge clock); #1;
  endtask

  initial begin
    logic signed [31:0] exp_q[$];
    int                 rdc_q[$];
    logic signed [31:0] xp_m;
    int                 reads, writes, guard;

    // Reset beats pending handshakes in the same cycle.
    reset = 1'b1; din = 32'sd1024; in_empty = 1'b0; out_full = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check(32'(in_rd_en), 0, "rst_rd_en");
    check(32'(out_wr_en), 0, "rst_wr_en");
    check(dout, 0, "rst_dout");
    reset = 1'b0; in_empty = 1'b1;

    // Step response
    feed(32'sd1024, "step0"); expect_write(32'sd2876, "step0");
    feed(32'sd1024, "step1"); expect_write(32'sd1006, "step1");
    feed(32'sd1024, "step2"); expect_write(32'sd1006, "step2");

    // Floor rounding of a small negative product
    do_reset();
    feed(32'sd1, "floor0"); expect_write(32'sd2, "floor0");
    feed(32'sd1, "floor1"); expect_write(32'sd0, "floor1");

    // Negative impulse
    do_reset();
    feed(-32'sd1024, "imp0"); expect_write(-32'sd2876, "imp0");
    feed(32'sd0, "imp1");     expect_write(32'sd1870, "imp1");

    // Backpressure: x_prev is 0 here, so the held output is 2876.
    @(negedge clock);
    out_full = 1'b1;
    feed(32'sd1024, "bp");
    repeat (3) @(posedge clock);
    @(negedge clock);
    din = 32'sd0; in_empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check(32'(out_wr_en), 0, "bp_hold_wr");
      check(32'(in_rd_en), 0, "bp_hold_rd");
      check(dout, 32'sd2876, "bp_hold_dout");
      @(negedge clock);
    end
    out_full = 1'b0;
    #1;
    check(32'(out_wr_en), 1, "bp_release_wr");
    check(32'(in_rd_en), 0, "bp_release_rd");
    check(dout, 32'sd2876, "bp_release_dout");
    @(negedge clock); #1;
    check(32'(in_rd_en), 1, "bp_next_read");
    check(32'(out_wr_en), 0, "bp_single_write");
    rd_cyc = cyc;
    @(posedge clock); #1;
    in_empty = 1'b1;
    expect_write(-32'sd1870, "bp_next");

    // Random starvation with a model scoreboard
    do_reset();
    xp_m = 0; reads = 0; writes = 0; guard = 0;
    while ((reads < 16 || exp_q.size() != 0) && guard < 2000) begin
      @(negedge clock);
      in_empty = (reads < 16) ? 1'($urandom_range(0, 1)) : 1'b1;
      din = $signed($urandom);
      #1;
      if (in_rd_en && out_wr_en) check(1, 0, "rnd_both_strobes");
      if (in_rd_en) begin
        check(32'(in_empty), 0, "rnd_rd_when_empty");
        exp_q.push_back(model(din, xp_m));
        rdc_q.push_back(cyc);
        xp_m = din;
        reads++;
      end
      if (out_wr_en) begin
        writes++;
        if (exp_q.size() == 0) check(writes, reads, "rnd_spurious_write");
        else begin
          check(dout, exp_q.pop_front(), "rnd_dout");
          check(cyc - rdc_q.pop_front(), 4, "rnd_latency");
        end
      end
      guard++;
    end
    check(writes, reads, "rnd_write_count");
    check(reads, 16, "rnd_read_count");

    // Reset while in S_DQ drops the sample and clears history.
    do_reset();
    feed(32'sd1024, "mid");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check(dout, 0, "mid_dout_cleared");
    writes = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); #1;
      if (out_wr_en) writes++;
    end
    check(writes, 0, "mid_no_write");
    feed(32'sd1024, "mid_next"); expect_write(32'sd2876, "mid_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
